// File: rtl/logic_axi4_stream_pkg.sv
// ----------------------------------------------------------------------------
// logic_axi4_stream_pkg
// Shared types and helpers for the AXI4-Stream utility blocks.
//   flush_reason_e      : why an upsizer handed a word to its output register
//   timer_count_width() : counter width needed to count 0..cycles-1
// ----------------------------------------------------------------------------
package logic_axi4_stream_pkg;

    typedef enum logic [1:0] {
        FULL    = 2'd0,   // all RATIO slots filled
        TLAST   = 2'd1,   // accepted beat carried tlast
        ROUTE   = 2'd2,   // incoming tdest/tid differs from the held word
        TIMEOUT = 2'd3    // accumulator sat idle for TIMEOUT_CYCLES
    } flush_reason_e;

    // The idle counter saturates at cycles-1, so it never needs to hold
    // the value 'cycles' itself. Never narrower than one bit.
    function automatic int timer_count_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/logic_axi4_stream_upsizer_flush_timer.sv
// ----------------------------------------------------------------------------
// logic_axi4_stream_upsizer_flush_timer
// Counts consecutive idle cycles of a non-empty accumulator and raises
// 'expire' during the cycle that completes TIMEOUT_CYCLES idle cycles.
// Ports:
//   aclk    : clock
//   areset  : synchronous active-high reset
//   active  : accumulator non-empty and no Rx handshake this cycle
//   expire  : idle run has reached TIMEOUT_CYCLES (stays high while blocked)
// ----------------------------------------------------------------------------
module logic_axi4_stream_upsizer_flush_timer
    import logic_axi4_stream_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1
) (
    input  logic aclk,
    input  logic areset,
    input  logic active,
    output logic expire
);

    localparam int CNT_W = timer_count_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    // count_reg holds the number of idle cycles already completed; the
    // current idle cycle is the one that reaches the limit, so the flush
    // lands exactly TIMEOUT_CYCLES edges after the last handshake.
    always_ff @(posedge aclk) begin
        if (areset || !active) begin
            count_reg <= '0;
        end else if (count_reg != CNT_MAX) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = active && (count_reg == CNT_MAX);

endmodule

// File: rtl/logic_axi4_stream_upsizer_flush.sv
// ----------------------------------------------------------------------------
// logic_axi4_stream_upsizer_flush
// AXI4-Stream width upsizer: packs RATIO narrow Rx beats little-endian into
// one Tx word. Partial words are flushed on tlast, on a tdest/tid change or
// after an idle timeout; unused lanes are zeroed.
// Ports:
//   aclk, areset                      : clock, synchronous active-high reset
//   rx_t*  (tvalid/tready/tdata/tstrb/tkeep/tlast/tuser/tdest/tid) : narrow in
//   tx_t*  (same set, RATIO x wider data/strb/keep/user)           : wide out
//   tx_flush_reason                   : FULL/TLAST/ROUTE/TIMEOUT, with tx_tvalid
// ----------------------------------------------------------------------------
module logic_axi4_stream_upsizer_flush
    import logic_axi4_stream_pkg::*;
#(
    parameter int RX_TDATA_BYTES = 4,
    parameter int RATIO          = 4,
    parameter int RX_TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                      aclk,
    input  logic                                      areset,

    input  logic                                      rx_tvalid,
    output logic                                      rx_tready,
    input  logic [RX_TDATA_BYTES*8-1:0]               rx_tdata,
    input  logic [RX_TDATA_BYTES-1:0]                 rx_tstrb,
    input  logic [RX_TDATA_BYTES-1:0]                 rx_tkeep,
    input  logic                                      rx_tlast,
    input  logic [RX_TUSER_WIDTH-1:0]                 rx_tuser,
    input  logic [TDEST_WIDTH-1:0]                    rx_tdest,
    input  logic [TID_WIDTH-1:0]                      rx_tid,

    output logic                                      tx_tvalid,
    input  logic                                      tx_tready,
    output logic [RATIO*RX_TDATA_BYTES*8-1:0]         tx_tdata,
    output logic [RATIO*RX_TDATA_BYTES-1:0]           tx_tstrb,
    output logic [RATIO*RX_TDATA_BYTES-1:0]           tx_tkeep,
    output logic                                      tx_tlast,
    output logic [RATIO*RX_TUSER_WIDTH-1:0]           tx_tuser,
    output logic [TDEST_WIDTH-1:0]                    tx_tdest,
    output logic [TID_WIDTH-1:0]                      tx_tid,
    output logic [1:0]                                tx_flush_reason
);

    localparam int TX_TDATA_BYTES = RATIO * RX_TDATA_BYTES;
    localparam int RX_W           = RX_TDATA_BYTES * 8;
    localparam int TX_W           = TX_TDATA_BYTES * 8;
    localparam int SLOT_W         = $clog2(RATIO);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    // ---------------- accumulator state ----------------
    logic [SLOT_W-1:0]      slot_reg, slot_next;
    logic [TDEST_WIDTH-1:0] acc_dest_reg;
    logic [TID_WIDTH-1:0]   acc_tid_reg;

    // ---------------- output register ----------------
    logic                        tx_valid_reg;
    logic [TX_W-1:0]             tx_data_reg;
    logic [TX_TDATA_BYTES-1:0]   tx_strb_reg;
    logic [TX_TDATA_BYTES-1:0]   tx_keep_reg;
    logic                        tx_last_reg;
    logic [RATIO*RX_TUSER_WIDTH-1:0] tx_user_reg;
    logic [TDEST_WIDTH-1:0]      tx_dest_reg;
    logic [TID_WIDTH-1:0]        tx_id_reg;
    flush_reason_e               tx_reason_reg;

    // ---------------- control ----------------
    logic acc_empty, route_change, beat_ends, out_free;
    logic rx_ready, rx_hs, handoff_rx, flush_route, flush_timeout, load_out;
    logic timeout_fire;
    flush_reason_e reason_next;

    // Assembled word (accumulated lanes plus the completing beat, if any)
    logic [TX_W-1:0]                 word_data;
    logic [TX_TDATA_BYTES-1:0]       word_strb;
    logic [TX_TDATA_BYTES-1:0]       word_keep;
    logic [RATIO*RX_TUSER_WIDTH-1:0] word_user;
    logic [TDEST_WIDTH-1:0]          word_dest;
    logic [TID_WIDTH-1:0]            word_tid;

    // Slot counter doubles as occupancy: it returns to 0 on every handoff.
    assign acc_empty    = (slot_reg == '0);
    assign route_change = rx_tvalid && !acc_empty &&
                          ((rx_tdest != acc_dest_reg) || (rx_tid != acc_tid_reg));
    assign beat_ends    = (slot_reg == LAST_SLOT) || rx_tlast;
    assign out_free     = !tx_valid_reg || tx_tready;

    // A beat that closes a word needs the output register; a route change
    // is never accepted directly because the old partial word goes first.
    assign rx_ready   = !areset && !route_change && (!beat_ends || out_free);
    assign rx_hs      = rx_tvalid && rx_ready;
    assign handoff_rx = rx_hs && beat_ends;

    // Route flush takes precedence over a coincident timeout expiry.
    assign flush_route   = route_change && out_free;
    assign flush_timeout = timeout_fire && out_free && !route_change;
    assign load_out      = handoff_rx || flush_route || flush_timeout;

    always_comb begin
        reason_next = TIMEOUT;
        if (handoff_rx) begin
            reason_next = rx_tlast ? TLAST : FULL;
        end else if (flush_route) begin
            reason_next = ROUTE;
        end
    end

    always_comb begin
        slot_next = slot_reg;
        if (load_out) begin
            slot_next = '0;
        end else if (rx_hs) begin
            slot_next = slot_reg + 1'b1;
        end
    end

    // Routing fields come from slot 0 of the word.
    assign word_dest = acc_empty ? rx_tdest : acc_dest_reg;
    assign word_tid  = acc_empty ? rx_tid   : acc_tid_reg;

    // ---------------- per-lane storage and word assembly ----------------
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam logic [SLOT_W-1:0] LANE = SLOT_W'(gi);

            logic [RX_W-1:0]           data_reg;
            logic [RX_TDATA_BYTES-1:0] strb_reg;
            logic [RX_TDATA_BYTES-1:0] keep_reg;
            logic [RX_TUSER_WIDTH-1:0] user_reg;
            logic                      from_acc;
            logic                      from_rx;

            // Lane storage only captures beats that do not close the word;
            // the closing beat goes straight into the output register.
            always_ff @(posedge aclk) begin
                if (rx_hs && !beat_ends && (slot_reg == LANE)) begin
                    data_reg <= rx_tdata;
                    strb_reg <= rx_tstrb;
                    keep_reg <= rx_tkeep;
                    user_reg <= rx_tuser;
                end
            end

            assign from_acc = (LANE < slot_reg);
            assign from_rx  = rx_hs && (LANE == slot_reg);

            // Lanes above the fill point read as zero, masking stale storage.
            assign word_data[gi*RX_W +: RX_W] =
                from_rx ? rx_tdata : (from_acc ? data_reg : '0);
            assign word_strb[gi*RX_TDATA_BYTES +: RX_TDATA_BYTES] =
                from_rx ? rx_tstrb : (from_acc ? strb_reg : '0);
            assign word_keep[gi*RX_TDATA_BYTES +: RX_TDATA_BYTES] =
                from_rx ? rx_tkeep : (from_acc ? keep_reg : '0);
            assign word_user[gi*RX_TUSER_WIDTH +: RX_TUSER_WIDTH] =
                from_rx ? rx_tuser : (from_acc ? user_reg : '0);
        end

        if (TIMEOUT_CYCLES > 0) begin : g_timer
            logic timer_active;
            assign timer_active = !acc_empty && !rx_hs;

            logic_axi4_stream_upsizer_flush_timer #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_timer (
                .aclk   (aclk),
                .areset (areset),
                .active (timer_active),
                .expire (timeout_fire)
            );
        end else begin : g_no_timer
            assign timeout_fire = 1'b0;
        end
    endgenerate

    // ---------------- sequential state ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            slot_reg      <= '0;
            acc_dest_reg  <= '0;
            acc_tid_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
            tx_strb_reg   <= '0;
            tx_keep_reg   <= '0;
            tx_last_reg   <= 1'b0;
            tx_user_reg   <= '0;
            tx_dest_reg   <= '0;
            tx_id_reg     <= '0;
            tx_reason_reg <= FULL;
        end else begin
            slot_reg <= slot_next;

            if (rx_hs && acc_empty) begin
                acc_dest_reg <= rx_tdest;
                acc_tid_reg  <= rx_tid;
            end

            if (load_out) begin
                tx_valid_reg  <= 1'b1;
                tx_data_reg   <= word_data;
                tx_strb_reg   <= word_strb;
                tx_keep_reg   <= word_keep;
                tx_last_reg   <= handoff_rx && rx_tlast;
                tx_user_reg   <= word_user;
                tx_dest_reg   <= word_dest;
                tx_id_reg     <= word_tid;
                tx_reason_reg <= reason_next;
            end else if (tx_tready) begin
                tx_valid_reg  <= 1'b0;
            end
        end
    end

    assign rx_tready       = rx_ready;
    assign tx_tvalid       = tx_valid_reg;
    assign tx_tdata        = tx_data_reg;
    assign tx_tstrb        = tx_strb_reg;
    assign tx_tkeep        = tx_keep_reg;
    assign tx_tlast        = tx_last_reg;
    assign tx_tuser        = tx_user_reg;
    assign tx_tdest        = tx_dest_reg;
    assign tx_tid          = tx_id_reg;
    assign tx_flush_reason = tx_reason_reg;

endmodule

// File: tb/tb_logic_axi4_stream_upsizer_flush.sv
// ----------------------------------------------------------------------------
// tb_logic_axi4_stream_upsizer_flush
// Scoreboard bench: expected Tx words are queued as each scenario is driven
// and compared field by field when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_logic_axi4_stream_upsizer_flush;

    localparam int RXB   = 4;
    localparam int RATIO = 4;
    localparam int UW    = 1;
    localparam int DW    = 2;
    localparam int IW    = 1;
    localparam int TO    = 5;

    logic         aclk   = 1'b0;
    logic         areset = 1'b1;
    logic         rx_tvalid = 1'b0;
    logic         rx_tready;
    logic [31:0]  rx_tdata = '0;
    logic [3:0]   rx_tstrb = '0;
    logic [3:0]   rx_tkeep = '0;
    logic         rx_tlast = 1'b0;
    logic [0:0]   rx_tuser = '0;
    logic [1:0]   rx_tdest = '0;
    logic [0:0]   rx_tid   = '0;
    logic         tx_tvalid;
    logic         tx_tready = 1'b1;
    logic [127:0] tx_tdata;
    logic [15:0]  tx_tstrb;
    logic [15:0]  tx_tkeep;
    logic         tx_tlast;
    logic [3:0]   tx_tuser;
    logic [1:0]   tx_tdest;
    logic [0:0]   tx_tid;
    logic [1:0]   tx_flush_reason;

    always #5 aclk = ~aclk;

    logic_axi4_stream_upsizer_flush #(
        .RX_TDATA_BYTES (RXB),
        .RATIO          (RATIO),
        .RX_TUSER_WIDTH (UW),
        .TDEST_WIDTH    (DW),
        .TID_WIDTH      (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .rx_tvalid       (rx_tvalid),
        .rx_tready       (rx_tready),
        .rx_tdata        (rx_tdata),
        .rx_tstrb        (rx_tstrb),
        .rx_tkeep        (rx_tkeep),
        .rx_tlast        (rx_tlast),
        .rx_tuser        (rx_tuser),
        .rx_tdest        (rx_tdest),
        .rx_tid          (rx_tid),
        .tx_tvalid       (tx_tvalid),
        .tx_tready       (tx_tready),
        .tx_tdata        (tx_tdata),
        .tx_tstrb        (tx_tstrb),
        .tx_tkeep        (tx_tkeep),
        .tx_tlast        (tx_tlast),
        .tx_tuser        (tx_tuser),
        .tx_tdest        (tx_tdest),
        .tx_tid          (tx_tid),
        .tx_flush_reason (tx_flush_reason)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic [3:0]   user;
        logic [1:0]   dest;
        logic         last;
        logic [1:0]   reason;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   pop_cyc      = 0;
    int   prev_pop_cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] d, input logic [15:0] k, input logic [3:0] u,
                            input logic [1:0] dest, input logic last, input logic [1:0] reason);
        exp_t e;
        e.data = d; e.keep = k; e.user = u; e.dest = dest; e.last = last; e.reason = reason;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor: scoreboard pop + stall stability ----------------
    logic         stall_prev = 1'b0;
    logic [127:0] snap_data;
    logic [15:0]  snap_keep;
    logic         snap_last;
    logic [1:0]   snap_reason;

    always @(negedge aclk) begin
        if (!areset) begin
            if (stall_prev) begin
                check_val("stall_stable_data", tx_tdata, snap_data);
                check_val("stall_stable_keep", tx_tkeep, snap_keep);
                check_val("stall_stable_last", tx_tlast, snap_last);
                check_val("stall_stable_reason", tx_flush_reason, snap_reason);
                check_val("stall_stable_valid", tx_tvalid, 1);
            end
            if (tx_tvalid && exp_q.size() == 0) begin
                check_val("spurious_tvalid", tx_tvalid, 0);
            end else if (tx_tvalid && tx_tready) begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("tx_tdata", tx_tdata, e.data);
                check_val("tx_tkeep", tx_tkeep, e.keep);
                check_val("tx_tstrb", tx_tstrb, e.keep);
                check_val("tx_tuser", tx_tuser, e.user);
                check_val("tx_tdest", tx_tdest, e.dest);
                check_val("tx_tid", tx_tid, 0);
                check_val("tx_tlast", tx_tlast, e.last);
                check_val("tx_flush_reason", tx_flush_reason, e.reason);
                $display("[TB] tx word data=0x%032h keep=0x%04h dest=%0d last=%0d reason=%0d",
                         tx_tdata, tx_tkeep, tx_tdest, tx_tlast, tx_flush_reason);
                prev_pop_cyc = pop_cyc;
                pop_cyc      = cyc;
            end
            stall_prev  = tx_tvalid && !tx_tready;
            snap_data   = tx_tdata;
            snap_keep   = tx_tkeep;
            snap_last   = tx_tlast;
            snap_reason = tx_flush_reason;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] dest,
                             output int stalls);
        logic hs;
        rx_tdata  = d;
        rx_tkeep  = 4'hF;
        rx_tstrb  = 4'hF;
        rx_tuser  = 1'b1;
        rx_tlast  = last;
        rx_tdest  = dest;
        rx_tid    = 1'b0;
        rx_tvalid = 1'b1;
        stalls    = 0;
        forever begin
            @(negedge aclk);
            hs = rx_tready;
            @(posedge aclk);
            #1;
            if (hs) break;
            stalls++;
            if (stalls > 200) begin
                check_val("rx_handshake_bound", stalls, 0);
                break;
            end
        end
    endtask

    task automatic rx_idle();
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge aclk);
            #2;
            n++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int st;
        int st_sum;
        int st8;
        int n;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_tvalid", tx_tvalid, 0);
        check_val("rst_rx_tready", rx_tready, 0);
        check_val("rst_tdata", tx_tdata, 0);
        check_val("rst_tkeep", tx_tkeep, 0);
        check_val("rst_reason", tx_flush_reason, 0);
        check_val("rst_tlast", tx_tlast, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;

        // Two full words, back-to-back beats
        push_exp(128'h44444444_33333333_22222222_11111111, 16'hFFFF, 4'hF, 2'd0, 1'b0, 2'd0);
        push_exp(128'h88888888_77777777_66666666_55555555, 16'hFFFF, 4'hF, 2'd0, 1'b0, 2'd0);
        st_sum = 0;
        for (int k = 1; k <= 8; k++) begin
            send_beat(32'h11111111 * k, 1'b0, 2'd0, st);
            st_sum += st;
        end
        rx_idle();
        wait_drain("full_drain");
        check_val("full_no_rx_stall", st_sum, 0);
        check_val("full_word_spacing", pop_cyc - prev_pop_cyc, 4);
        $display("[TB] full words done");

        // tlast on third beat
        push_exp(128'h00000000_C3C3C3C3_B2B2B2B2_A1A1A1A1, 16'h0FFF, 4'h7, 2'd0, 1'b1, 2'd1);
        send_beat(32'hA1A1A1A1, 1'b0, 2'd0, st);
        send_beat(32'hB2B2B2B2, 1'b0, 2'd0, st);
        send_beat(32'hC3C3C3C3, 1'b1, 2'd0, st);
        rx_idle();
        wait_drain("tlast_drain");
        $display("[TB] tlast partial done");

        // tdest change flushes the partial word
        push_exp(128'h00000000_00000000_02020202_01010101, 16'h00FF, 4'h3, 2'd1, 1'b0, 2'd2);
        push_exp(128'h00000000_00000000_04040404_03030303, 16'h00FF, 4'h3, 2'd2, 1'b1, 2'd1);
        send_beat(32'h01010101, 1'b0, 2'd1, st);
        send_beat(32'h02020202, 1'b0, 2'd1, st);
        send_beat(32'h03030303, 1'b0, 2'd2, st);
        check_val("route_rx_stall_cycles", st, 1);
        send_beat(32'h04040404, 1'b1, 2'd2, st);
        rx_idle();
        wait_drain("route_drain");
        $display("[TB] route flush done");

        // Idle timeout
        push_exp(128'h00000000_00000000_00000000_5A5A5A5A, 16'h000F, 4'h1, 2'd0, 1'b0, 2'd3);
        send_beat(32'h5A5A5A5A, 1'b0, 2'd0, st);
        rx_idle();
        n = 0;
        while (n < 20) begin
            @(posedge aclk);
            #1;
            n++;
            if (tx_tvalid) break;
        end
        check_val("timeout_latency", n, 5);
        wait_drain("timeout_drain");
        $display("[TB] timeout flush done");

        // Output stalled for 10 cycles during an 8-beat stream
        push_exp(128'h24242424_23232323_22222222_21212121, 16'hFFFF, 4'hF, 2'd0, 1'b0, 2'd0);
        push_exp(128'h28282828_27272727_26262626_25252525, 16'hFFFF, 4'hF, 2'd0, 1'b0, 2'd0);
        tx_tready = 1'b0;
        st_sum = 0;
        st8 = 0;
        fork
            begin
                repeat (10) @(posedge aclk);
                #1 tx_tready = 1'b1;
            end
            begin
                for (int k = 1; k <= 8; k++) begin
                    send_beat({4{8'(8'h20 + k)}}, 1'b0, 2'd0, st);
                    if (k < 8) st_sum += st;
                    else       st8 = st;
                end
            end
        join
        rx_idle();
        wait_drain("stall_drain");
        check_val("stall_beats1to7_no_stall", st_sum, 0);
        check_val("stall_beat8_stalled", (st8 > 0), 1);
        $display("[TB] tx backpressure done");

        // Reset mid-packet
        send_beat(32'h31313131, 1'b0, 2'd0, st);
        send_beat(32'h32323232, 1'b0, 2'd0, st);
        rx_idle();
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check_val("midrst_tvalid", tx_tvalid, 0);
        check_val("midrst_tkeep", tx_tkeep, 0);
        check_val("midrst_tdata", tx_tdata, 0);
        check_val("midrst_rx_tready", rx_tready, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        repeat (8) @(posedge aclk);
        #1;
        check_val("postrst_idle_tvalid", tx_tvalid, 0);
        push_exp(128'h44444444_43434343_42424242_41414141, 16'hFFFF, 4'hF, 2'd0, 1'b0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            send_beat({4{8'(8'h40 + k)}}, 1'b0, 2'd0, st);
        end
        rx_idle();
        wait_drain("postrst_drain");
        repeat (10) @(posedge aclk);
        #1;
        check_val("final_tvalid_quiet", tx_tvalid, 0);
        $display("[TB] reset mid-packet done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
